eeprom_addr_unit: RTL and testbench
===================================

EEPROM_ADDR_UNIT -- requirements
Module: eeprom_addr_unit

Interface
REQ-001 Parameter ADDR_W, default 8, memory address width in bits; legal range 4..16.
REQ-002 Parameter ADDR_BYTES, default 1, number of address bytes received after a write START; legal values 1 or 2; ADDR_W SHALL NOT exceed 8*ADDR_BYTES.
REQ-003 Parameter PAGE_W, default 3, log2 of page size in bytes for write-pointer wrap; legal range 1..ADDR_W.
REQ-004 Parameter COL_W, default 3, number of low address bits presented as col; legal range 1..ADDR_W-1.
REQ-005 clk  input  1  single clock; all state changes on rising edge.
REQ-006 rst_n  input  1  asynchronous, active-low reset.
REQ-007 start  input  1  one-cycle pulse: START or repeated START decoded.
REQ-008 stop  input  1  one-cycle pulse: STOP decoded.
REQ-009 rw  input  1  transfer direction, sampled only with start; 1 = read.
REQ-010 bit_stb  input  1  one-cycle pulse per SCL rising edge carrying a data bit.
REQ-011 sda_bit  input  1  serial bit value, valid when bit_stb=1, MSB first.
REQ-012 rd_ack  input  1  one-cycle pulse: master ACKed a read byte.
REQ-013 addr  output  ADDR_W  current word pointer.
REQ-014 row  output  ADDR_W-COL_W  addr[ADDR_W-1:COL_W].
REQ-015 col  output  COL_W  addr[COL_W-1:0].
REQ-016 data_word  output  8  last fully received write data byte.
REQ-017 wr_en  output  1  one-cycle memory write strobe.
REQ-018 byte_done  output  1  one-cycle pulse on every completed 8-bit byte in any active state.
REQ-019 busy  output  1  high whenever state is not IDLE.

Function
REQ-020 States SHALL be IDLE, ADDR, DATA_WR, DATA_RD.
REQ-021 start with rw=0 SHALL enter ADDR with address-byte count 0; start with rw=1 SHALL enter DATA_RD; start is accepted in every state, including mid-byte.
REQ-022 stop SHALL enter IDLE from any state; addr is retained.
REQ-023 A 3-bit bit counter SHALL clear on start, stop and byte completion, and increment on each bit_stb in ADDR, DATA_WR and DATA_RD; bit_stb in IDLE is ignored.
REQ-024 An 8-bit shift register SHALL shift sda_bit in on each counted bit_stb, MSB first.
REQ-025 The eighth counted bit_stb SHALL assert byte_done in the following cycle, with latency exactly 1 clk.
REQ-026 In ADDR, each completed byte SHALL load addr, big-endian; with ADDR_BYTES=2, the first byte is the high byte; bits above ADDR_W are discarded; after ADDR_BYTES bytes, the state SHALL become DATA_WR.
REQ-027 In DATA_WR, each completed byte SHALL, in the byte_done cycle, load data_word and assert wr_en, with addr still holding the target address.
REQ-028 On the cycle after wr_en, addr SHALL increment within its page: addr[PAGE_W-1:0] wraps modulo 2^PAGE_W, and addr[ADDR_W-1:PAGE_W] is unchanged.
REQ-029 In DATA_RD, rd_ack SHALL increment addr modulo 2^ADDR_W (full-array wrap); completed bytes assert byte_done only; wr_en stays 0.
REQ-030 A byte left incomplete by start or stop SHALL be discarded: no wr_en, no addr or data_word change.
REQ-031 Simultaneous events: start or stop in the same cycle as bit_stb SHALL win, and the bit is dropped; stop together with start SHALL be treated as start; rd_ack outside DATA_RD is ignored.
REQ-032 wr_en SHALL never assert outside DATA_WR and never for two consecutive cycles.

Reset
REQ-033 rst_n=0 SHALL asynchronously force: state IDLE, bit counter 0, shift register 0, addr 0, data_word 0x00, wr_en 0, byte_done 0, busy 0.
REQ-034 Reset asserted mid-transfer SHALL abort without a write; after release, the block waits in IDLE for start.

Verification (default parameters unless stated)
REQ-035 Assert rst_n=0 for 3 cycles during an ADDR byte -> addr=0x00, data_word=0x00, busy=0, wr_en=0, with no wr_en after release.
REQ-036 start rw=0, address 0x05, data 0xA1,0xB2,0xC3,0xD4, stop -> four wr_en pulses at addr 0x05,0x06,0x07,0x00 (page wrap); final addr=0x01; data_word=0xD4.
REQ-037 Set addr=0xFF, then start rw=1 with two rd_ack -> addr 0x00, then 0x01; wr_en never asserts.
REQ-038 start rw=0, address 0x10, 5 data bits, then stop -> no wr_en; addr=0x10; data_word unchanged.
REQ-039 start and bit_stb in the same cycle, followed by 8 bits -> exactly one byte_done, and the first bit is excluded from the byte.
REQ-040 ADDR_W=12, ADDR_BYTES=2: address bytes 0xF3,0x4C, then one data byte -> wr_en at addr 0x34C; row=0x69, col=0x4.

Source files
------------

// File: rtl/eeprom_addr_unit.sv
// ----------------------------------------------------------------------------
// eeprom_addr_unit
//
// Address/data sequencer for a serial (I2C-style) EEPROM slave. It assembles
// serial bits into bytes, loads the word pointer from the address bytes that
// follow a write START, issues one memory write strobe per received data
// byte, and advances the pointer for writes (page wrap) and reads (full-array
// wrap).
//
// Parameters
//   ADDR_W      memory address width (4..16)
//   ADDR_BYTES  address bytes after a write START (1 or 2, big-endian)
//   PAGE_W      log2 of the write page size (1..ADDR_W)
//   COL_W       low address bits presented on col (1..ADDR_W-1)
//
// Ports
//   clk        clock, rising edge
//   rst_n      asynchronous active-low reset
//   start      START / repeated START pulse (rw sampled with it, 1 = read)
//   stop       STOP pulse
//   rw         transfer direction
//   bit_stb    one pulse per received data bit
//   sda_bit    received bit value, MSB first
//   rd_ack     master acknowledged a read byte
//   addr       current word pointer
//   row, col   addr split into high and low fields
//   data_word  last fully received write data byte
//   wr_en      one-cycle memory write strobe
//   byte_done  one-cycle pulse per completed byte
//   busy       block is inside a transfer
// ----------------------------------------------------------------------------
module eeprom_addr_unit #(
    parameter int ADDR_W     = 8,
    parameter int ADDR_BYTES = 1,
    parameter int PAGE_W     = 3,
    parameter int COL_W      = 3
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    start,
    input  logic                    stop,
    input  logic                    rw,
    input  logic                    bit_stb,
    input  logic                    sda_bit,
    input  logic                    rd_ack,
    output logic [ADDR_W-1:0]       addr,
    output logic [ADDR_W-COL_W-1:0] row,
    output logic [COL_W-1:0]        col,
    output logic [7:0]              data_word,
    output logic                    wr_en,
    output logic                    byte_done,
    output logic                    busy
);

    typedef enum logic [1:0] {
        S_IDLE,
        S_ADDR,
        S_DATA_WR,
        S_DATA_RD
    } state_t;

    // Low PAGE_W bits of the pointer roll over inside a page on writes.
    localparam logic [ADDR_W-1:0] PAGE_MASK = ADDR_W'((32'd1 << PAGE_W) - 32'd1);

    state_t      state_q;
    state_t      state_d;
    logic [2:0]  bit_cnt;
    logic [7:0]  shreg;
    logic        addr_cnt;

    logic        bit_take;
    logic        byte_end;
    logic [7:0]  byte_val;
    logic        addr_last;
    logic [15:0] addr_shift;
    logic [ADDR_W-1:0] addr_load;
    logic [ADDR_W-1:0] addr_page_inc;

    // A bit only counts inside a transfer and when no START/STOP competes
    // with it; framing events always win and the bit is dropped.
    assign bit_take  = bit_stb && !start && !stop && (state_q != S_IDLE);
    assign byte_end  = bit_take && (bit_cnt == 3'd7);
    // Shift by one and drop the oldest bit: this is the completed byte.
    assign byte_val  = 8'({shreg, sda_bit});
    assign addr_last = (addr_cnt == 1'(ADDR_BYTES - 1));

    always_comb begin
        // NOTE: every combinational output gets a default first so no path
        // leaves it unassigned, which would otherwise infer a latch.
        addr_shift = 16'h0000;
        if (ADDR_BYTES == 2 && addr_cnt == 1'b0) begin
            // First of two bytes is the high byte.
            addr_shift = {byte_val, 8'h00};
        end else begin
            // Keep what already sits in the high byte, append the new low byte.
            addr_shift = (16'(addr) & 16'hFF00) | 16'(byte_val);
        end
    end

    // Bits above ADDR_W are discarded by the truncating cast.
    assign addr_load     = ADDR_W'(addr_shift);
    assign addr_page_inc = (addr & ~PAGE_MASK) | ((addr + ADDR_W'(1)) & PAGE_MASK);

    // ------------------------------------------------------------------------
    // State machine
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        // NOTE: sequential state uses non-blocking assignments so every
        // register samples the pre-edge values of the others.
        if (!rst_n) begin
            state_q <= S_IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        if (start) begin
            // START beats a simultaneous STOP.
            state_d = rw ? S_DATA_RD : S_ADDR;
        end else if (stop) begin
            state_d = S_IDLE;
        end else if (state_q == S_ADDR && byte_end && addr_last) begin
            state_d = S_DATA_WR;
        end
    end

    // ------------------------------------------------------------------------
    // Datapath
    // ------------------------------------------------------------------------
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            bit_cnt   <= 3'd0;
            shreg     <= 8'h00;
            addr_cnt  <= 1'b0;
            addr      <= '0;
            data_word <= 8'h00;
            wr_en     <= 1'b0;
            byte_done <= 1'b0;
        end else begin
            byte_done <= byte_end;
            wr_en     <= byte_end && (state_q == S_DATA_WR);

            // A byte interrupted by START/STOP simply restarts the count;
            // nothing downstream was touched, so it is discarded.
            if (start || stop) begin
                bit_cnt <= 3'd0;
            end else if (bit_take) begin
                bit_cnt <= byte_end ? 3'd0 : bit_cnt + 3'd1;
            end

            if (bit_take) begin
                shreg <= byte_val;
            end

            if (start) begin
                addr_cnt <= 1'b0;
            end else if (state_q == S_ADDR && byte_end) begin
                addr_cnt <= addr_cnt + 1'b1;
            end

            if (state_q == S_DATA_WR && byte_end) begin
                data_word <= byte_val;
            end

            // wr_en is visible with the target address; the pointer moves on
            // the edge that ends the strobe.
            if (state_q == S_ADDR && byte_end) begin
                addr <= addr_load;
            end else if (wr_en) begin
                addr <= addr_page_inc;
            end else if (state_q == S_DATA_RD && rd_ack) begin
                addr <= addr + ADDR_W'(1);
            end
        end
    end

    assign busy = (state_q != S_IDLE);
    assign row  = addr[ADDR_W-1:COL_W];
    assign col  = addr[COL_W-1:0];

endmodule

// File: tb/tb_eeprom_addr_unit.sv
// ----------------------------------------------------------------------------
// tb_eeprom_addr_unit
//
// Two instances share one stimulus stream: the default configuration and a
// 12-bit, two-address-byte configuration. A transaction-level reference model
// (modes, byte arithmetic, an expected-write queue per instance) predicts
// byte_done per bit, every write (address + data) and the resting pointer.
// ----------------------------------------------------------------------------
module tb_eeprom_addr_unit;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    logic start = 1'b0, stop = 1'b0, rw = 1'b0;
    logic bit_stb = 1'b0, sda_bit = 1'b0, rd_ack = 1'b0;

    logic [7:0]  addr0;
    logic [4:0]  row0;
    logic [2:0]  col0;
    logic [7:0]  data_word0;
    logic        wr_en0, byte_done0, busy0;

    logic [11:0] addr1;
    logic [8:0]  row1;
    logic [2:0]  col1;
    logic [7:0]  data_word1;
    logic        wr_en1, byte_done1, busy1;

    eeprom_addr_unit u_dut0 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .rw(rw),
        .bit_stb(bit_stb), .sda_bit(sda_bit), .rd_ack(rd_ack),
        .addr(addr0), .row(row0), .col(col0), .data_word(data_word0),
        .wr_en(wr_en0), .byte_done(byte_done0), .busy(busy0)
    );

    eeprom_addr_unit #(.ADDR_W(12), .ADDR_BYTES(2), .PAGE_W(3), .COL_W(3)) u_dut1 (
        .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .rw(rw),
        .bit_stb(bit_stb), .sda_bit(sda_bit), .rd_ack(rd_ack),
        .addr(addr1), .row(row1), .col(col1), .data_word(data_word1),
        .wr_en(wr_en1), .byte_done(byte_done1), .busy(busy1)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    task automatic check(string tag, logic [31:0] obs, logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Reference model: mode 0 idle, 1 address, 2 write data, 3 read data
    // ------------------------------------------------------------------------
    localparam int PW = 3;
    int m_mode[2], m_bits[2], m_sh[2], m_abuf[2], m_acnt[2], m_addr[2], m_data[2];
    bit m_known[2];
    logic [23:0] q0[$];
    logic [23:0] q1[$];

    function automatic int aw(int d); return (d == 0) ? 8 : 12; endfunction
    function automatic int ab(int d); return (d == 0) ? 1 : 2;  endfunction

    function automatic void model_reset();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_bits[d] = 0; m_sh[d] = 0; m_abuf[d] = 0;
            m_acnt[d] = 0; m_addr[d] = 0; m_data[d] = 0; m_known[d] = 1'b1;
        end
        q0.delete();
        q1.delete();
    endfunction

    function automatic void model_start(bit r);
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = r ? 3 : 1; m_bits[d] = 0; m_abuf[d] = 0; m_acnt[d] = 0;
        end
    endfunction

    function automatic void model_stop();
        for (int d = 0; d < 2; d++) begin
            m_mode[d] = 0; m_bits[d] = 0;
        end
    endfunction

    function automatic void model_ack();
        for (int d = 0; d < 2; d++)
            if (m_mode[d] == 3) m_addr[d] = (m_addr[d] + 1) % (1 << aw(d));
    endfunction

    // Returns 1 when this bit completes a byte.
    function automatic bit model_bit(int d, bit b);
        int page;
        int bytev;
        if (m_mode[d] == 0) return 1'b0;
        m_sh[d] = ((m_sh[d] << 1) | int'(b)) & 255;
        m_bits[d]++;
        if (m_bits[d] < 8) return 1'b0;
        m_bits[d] = 0;
        bytev = m_sh[d];
        if (m_mode[d] == 1) begin
            m_abuf[d] = m_abuf[d] * 256 + bytev;
            m_acnt[d]++;
            if (m_acnt[d] == ab(d)) begin
                m_addr[d]  = m_abuf[d] % (1 << aw(d));
                m_known[d] = 1'b1;
                m_mode[d]  = 2;
            end else begin
                m_known[d] = 1'b0;
            end
        end else if (m_mode[d] == 2) begin
            if (d == 0) q0.push_back({16'(m_addr[d]), 8'(bytev)});
            else        q1.push_back({16'(m_addr[d]), 8'(bytev)});
            m_data[d] = bytev;
            page = 1 << PW;
            m_addr[d] = (m_addr[d] / page) * page + (m_addr[d] + 1) % page;
        end
        return 1'b1;
    endfunction

    // ------------------------------------------------------------------------
    // Write monitor
    // ------------------------------------------------------------------------
    bit prev_we[2];
    int wr_cnt[2];

    task automatic mon(int d, logic we, logic [15:0] a, logic [7:0] dw);
        logic [23:0] e;
        if (we) begin
            wr_cnt[d]++;
            check($sformatf("wr_back_to_back%0d", d), 32'(prev_we[d]), 0);
            if ((d == 0 ? q0.size() : q1.size()) == 0) begin
                check($sformatf("wr_unexpected%0d", d), 32'(we), 0);
            end else begin
                e = (d == 0) ? q0.pop_front() : q1.pop_front();
                check($sformatf("wr_addr%0d", d), 32'(a), 32'(e[23:8]));
                check($sformatf("wr_data%0d", d), 32'(dw), 32'(e[7:0]));
            end
        end
        prev_we[d] = we;
    endtask

    always @(negedge clk) begin
        if (rst_n) begin
            mon(0, wr_en0, 16'(addr0), data_word0);
            mon(1, wr_en1, 16'(addr1), data_word1);
        end else begin
            prev_we[0] = 1'b0;
            prev_we[1] = 1'b0;
        end
    end

    // ------------------------------------------------------------------------
    // Drivers
    // ------------------------------------------------------------------------
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic send_bit(bit b);
        bit e0, e1;
        repeat ($urandom_range(0, 1)) tick();
        bit_stb = 1'b1; sda_bit = b;
        e0 = model_bit(0, b);
        e1 = model_bit(1, b);
        tick();
        bit_stb = 1'b0; sda_bit = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("byte_done0", 32'(byte_done0), 32'(e0));
        check("byte_done1", 32'(byte_done1), 32'(e1));
    endtask

    task automatic send_byte(logic [7:0] v);
        for (int i = 7; i >= 0; i--) send_bit(v[i]);
    endtask

    task automatic send_start(bit r, bit with_stop, bit with_bit, bit b);
        start = 1'b1; rw = r; stop = with_stop; bit_stb = with_bit; sda_bit = b;
        model_start(r);
        tick();
        start = 1'b0; stop = 1'b0; bit_stb = 1'b0;
        rw = 1'($urandom_range(0, 1));
        @(negedge clk);
        check("start_byte_done", 32'(byte_done0), 0);
        check("start_busy", 32'(busy0), 1);
    endtask

    task automatic send_stop();
        stop = 1'b1;
        model_stop();
        tick();
        stop = 1'b0;
        @(negedge clk);
        check("stop_busy", 32'(busy0), 0);
    endtask

    task automatic send_ack();
        rd_ack = 1'b1;
        model_ack();
        tick();
        rd_ack = 1'b0;
    endtask

    // Compare the resting state one cycle later, after any pointer advance.
    task automatic checkpoint(string tag);
        tick();
        @(negedge clk);
        if (m_known[0]) begin
            check({tag, "_addr0"}, 32'(addr0), 32'(m_addr[0]));
            check({tag, "_row0"},  32'(row0),  32'(m_addr[0] >> 3));
            check({tag, "_col0"},  32'(col0),  32'(m_addr[0] % 8));
        end
        if (m_known[1]) begin
            check({tag, "_addr1"}, 32'(addr1), 32'(m_addr[1]));
            check({tag, "_row1"},  32'(row1),  32'(m_addr[1] >> 3));
        end
        check({tag, "_data0"}, 32'(data_word0), 32'(m_data[0]));
        check({tag, "_data1"}, 32'(data_word1), 32'(m_data[1]));
        check({tag, "_busy0"}, 32'(busy0), 32'(m_mode[0] != 0));
        check({tag, "_busy1"}, 32'(busy1), 32'(m_mode[1] != 0));
    endtask

    task automatic do_reset(int cycles);
        rst_n = 1'b0; start = 1'b0; stop = 1'b0; bit_stb = 1'b0; rd_ack = 1'b0;
        model_reset();
        @(negedge clk);
        check("rst_addr0",  32'(addr0), 0);
        check("rst_data0",  32'(data_word0), 0);
        check("rst_busy0",  32'(busy0), 0);
        check("rst_wr_en0", 32'(wr_en0), 0);
        check("rst_bd0",    32'(byte_done0), 0);
        check("rst_addr1",  32'(addr1), 0);
        check("rst_busy1",  32'(busy1), 0);
        repeat (cycles) @(posedge clk);
        #1 rst_n = 1'b1;
    endtask

    // ------------------------------------------------------------------------
    // Stimulus
    // ------------------------------------------------------------------------
    initial begin
        int base;
        bit r;
        model_reset();
        do_reset(3);
        checkpoint("reset");

        // Write burst crossing a page boundary.
        base = wr_cnt[0];
        send_start(1'b0, 1'b0, 1'b0, 1'b0);
        send_byte(8'h05);
        send_byte(8'hA1); send_byte(8'hB2); send_byte(8'hC3); send_byte(8'hD4);
        send_stop();
        checkpoint("page_wrap");
        check("page_wrap_count", 32'(wr_cnt[0] - base), 4);

        // Incomplete data byte is discarded.
        base = wr_cnt[0];
        send_start(1'b0, 1'b0, 1'b0, 1'b0);
        send_byte(8'h10);
        for (int i = 0; i < 5; i++) send_bit(1'($urandom_range(0, 1)));
        send_stop();
        checkpoint("partial");
        check("partial_count", 32'(wr_cnt[0] - base), 0);

        // Read pointer wraps across the whole array.
        send_start(1'b0, 1'b0, 1'b0, 1'b0);
        send_byte(8'hFF);
        send_stop();
        checkpoint("set_ff");
        base = wr_cnt[0];
        send_start(1'b1, 1'b0, 1'b0, 1'b0);
        send_ack();
        checkpoint("rd_ack1");
        send_ack();
        checkpoint("rd_ack2");
        send_byte(8'h3C);
        send_stop();
        checkpoint("rd_end");
        check("rd_no_write", 32'(wr_cnt[0] - base), 0);

        // START coinciding with a bit: the bit is not part of the byte.
        send_start(1'b0, 1'b0, 1'b1, 1'b1);
        send_byte(8'h5A);
        send_stop();
        checkpoint("start_bit");

        // STOP together with START behaves as START.
        send_start(1'b0, 1'b1, 1'b0, 1'b0);
        send_byte(8'h21);
        send_byte(8'h77);
        send_stop();
        checkpoint("stop_start");

        // Reset in the middle of an address byte.
        base = wr_cnt[0];
        send_start(1'b0, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 4; i++) send_bit(1'b1);
        do_reset(3);
        for (int i = 0; i < 10; i++) send_bit(1'($urandom_range(0, 1)));
        checkpoint("mid_reset");
        check("mid_reset_writes", 32'(wr_cnt[0] - base), 0);

        // Two address bytes on the 12-bit instance.
        do_reset(2);
        send_start(1'b0, 1'b0, 1'b0, 1'b0);
        send_byte(8'hF3);
        send_byte(8'h4C);
        send_byte(8'h9E);
        check("addr2_wr_en", 32'(wr_en1), 1);
        check("addr2_addr",  32'(addr1), 32'h34C);
        check("addr2_row",   32'(row1),  32'h69);
        check("addr2_col",   32'(col1),  32'h4);
        send_stop();
        checkpoint("addr2");

        // Randomized transactions.
        for (int t = 0; t < 40; t++) begin
            r = ($urandom_range(0, 3) == 0);
            send_start(r, ($urandom_range(0, 7) == 0), ($urandom_range(0, 5) == 0),
                       1'($urandom_range(0, 1)));
            if (!r) begin
                send_byte(8'($urandom));
                send_byte(8'($urandom));
                repeat ($urandom_range(0, 4)) begin
                    if ($urandom_range(0, 5) == 0) send_ack();
                    send_byte(8'($urandom));
                end
            end else begin
                repeat ($urandom_range(1, 4)) begin
                    if ($urandom_range(0, 1) == 1) send_ack();
                    else send_byte(8'($urandom));
                end
            end
            if ($urandom_range(0, 2) == 0)
                for (int i = 0; i < int'($urandom_range(1, 7)); i++)
                    send_bit(1'($urandom_range(0, 1)));
            if ($urandom_range(0, 4) != 0) begin
                send_stop();
                checkpoint("rand");
            end
        end
        send_stop();
        checkpoint("final");
        check("pending_writes0", 32'(q0.size()), 0);
        check("pending_writes1", 32'(q1.size()), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
